// File: rtl/processor_debug_pkg.sv
// Shared op codes, FSM states and register indices for the processor debug controller.
package processor_debug_pkg;

   typedef enum logic [2:0] {
      OP_STATUS   = 3'd0,
      OP_CONTINUE = 3'd1,
      OP_READ_REG = 3'd2,
      OP_DUMP     = 3'd3,
      OP_STEP     = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_SETUP,
      ST_RD_CAPTURE,
      ST_RSP_WAIT,
      ST_CONT_PULSE,
      ST_STEP_WAIT_LOW,
      ST_STEP_WAIT_HIGH
   } state_e;

   localparam logic [3:0] DEBUG_REG_IP   = 4'd8;
   localparam logic [3:0] DEBUG_REG_LAST = 4'd8;

endpackage

// File: rtl/processor_debug_ctrl.sv
// Host-side debug sequencer: status, continue, register read/dump, single step (STEP only with PROCESSOR_DEBUG_CTRL_STEP_EN).
// Latency: register read responds 2 cycles after accept, status/errors at accept; dump costs 3 cycles per register.
// Backpressure: one command in flight; rsp_* held stable until rsp_ready, cmd_ready low until the final response is taken.
module processor_debug_ctrl
   import processor_debug_pkg::*;
#(
   parameter int WORD_SIZE    = 18,
   parameter int STEP_TIMEOUT = 1024
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [3:0]           cmd_reg,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WORD_SIZE-1:0] rsp_data,
   output logic [3:0]           rsp_tag,
   output logic                 rsp_err,
   input  logic                 cpu_wait_for_continue,
   output logic                 cpu_wait_continue_execution,
   output logic                 cpu_debug_get_param,
   output logic [3:0]           cpu_debug_reg_addr,
   input  logic [WORD_SIZE-1:0] cpu_debug_data,
   output logic                 busy
);

   if (STEP_TIMEOUT < 2) begin : g_bad_step_timeout
      $error("STEP_TIMEOUT must be at least 2");
   end

   state_e               state, state_nxt;
   logic [3:0]           idx, idx_nxt;
   logic                 dump_active, dump_nxt;
   logic                 rsp_set, rsp_err_nxt, rsp_valid_nxt, reject;
   logic [WORD_SIZE-1:0] rsp_data_nxt;
   logic [3:0]           rsp_tag_nxt;
   logic                 accept, rsp_hs;

   assign accept        = cmd_valid & cmd_ready;
   assign rsp_hs        = rsp_valid & rsp_ready;
   assign rsp_valid_nxt = rsp_set | (rsp_valid & ~rsp_ready);

`ifdef PROCESSOR_DEBUG_CTRL_STEP_EN
   localparam int TW = $clog2(STEP_TIMEOUT);
   logic                 step_active, step_nxt;
   logic [WORD_SIZE-1:0] cnt, cnt_inc;
   logic [TW-1:0]        wcnt;
   logic                 wait_expired;

   assign cnt_inc      = (&cnt) ? cnt : cnt + WORD_SIZE'(1);
   assign wait_expired = (wcnt == TW'(STEP_TIMEOUT - 1));
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      dump_nxt     = dump_active;
      rsp_set      = 1'b0;
      rsp_data_nxt = '0;
      rsp_tag_nxt  = '0;
      rsp_err_nxt  = 1'b0;
      reject       = 1'b0;
`ifdef PROCESSOR_DEBUG_CTRL_STEP_EN
      step_nxt     = step_active;
`endif
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_STATUS: begin
                     rsp_set      = 1'b1;
                     rsp_data_nxt = WORD_SIZE'(cpu_wait_for_continue);
                     state_nxt    = ST_RSP_WAIT;
                  end
                  OP_CONTINUE: begin
                     if (cpu_wait_for_continue) state_nxt = ST_CONT_PULSE;
                     else                       reject    = 1'b1;
                  end
                  OP_READ_REG: begin
                     if (cpu_wait_for_continue && cmd_reg <= DEBUG_REG_LAST) begin
                        idx_nxt   = cmd_reg;
                        state_nxt = ST_RD_SETUP;
                     end else begin
                        reject = 1'b1;
                     end
                  end
                  OP_DUMP: begin
                     if (cpu_wait_for_continue) begin
                        idx_nxt   = 4'd0;
                        dump_nxt  = 1'b1;
                        state_nxt = ST_RD_SETUP;
                     end else begin
                        reject = 1'b1;
                     end
                  end
`ifdef PROCESSOR_DEBUG_CTRL_STEP_EN
                  OP_STEP: begin
                     if (cpu_wait_for_continue) begin
                        step_nxt  = 1'b1;
                        state_nxt = ST_CONT_PULSE;
                     end else begin
                        reject = 1'b1;
                     end
                  end
`endif
                  default: reject = 1'b1;
               endcase
               if (reject) begin
                  rsp_set     = 1'b1;
                  rsp_err_nxt = 1'b1;
                  state_nxt   = ST_RSP_WAIT;
               end
            end
         end
         ST_RD_SETUP: state_nxt = ST_RD_CAPTURE;
         ST_RD_CAPTURE: begin
            rsp_set      = 1'b1;
            rsp_data_nxt = cpu_debug_data;
            rsp_tag_nxt  = idx;
            state_nxt    = ST_RSP_WAIT;
         end
         ST_RSP_WAIT: begin
            if (rsp_hs) begin
               if (dump_active && idx != DEBUG_REG_LAST) begin
                  idx_nxt   = idx + 4'd1;
                  state_nxt = ST_RD_SETUP;
               end else begin
                  dump_nxt  = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_CONT_PULSE: begin
`ifdef PROCESSOR_DEBUG_CTRL_STEP_EN
            if (step_active) state_nxt = ST_STEP_WAIT_LOW;
            else
`endif
            begin
               rsp_set   = 1'b1;
               state_nxt = ST_RSP_WAIT;
            end
         end
`ifdef PROCESSOR_DEBUG_CTRL_STEP_EN
         ST_STEP_WAIT_LOW: begin
            if (!cpu_wait_for_continue) begin
               state_nxt = ST_STEP_WAIT_HIGH;
            end else if (wait_expired) begin
               rsp_set     = 1'b1;
               rsp_err_nxt = 1'b1;
               step_nxt    = 1'b0;
               state_nxt   = ST_RSP_WAIT;
            end
         end
         ST_STEP_WAIT_HIGH: begin
            if (cpu_wait_for_continue) begin
               rsp_set      = 1'b1;
               rsp_data_nxt = cnt_inc;
               step_nxt     = 1'b0;
               state_nxt    = ST_RSP_WAIT;
            end else if (wait_expired) begin
               rsp_set     = 1'b1;
               rsp_err_nxt = 1'b1;
               step_nxt    = 1'b0;
               state_nxt   = ST_RSP_WAIT;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The read port stays frozen across a whole dump, including while each response waits.
   always_comb begin
      cpu_wait_continue_execution = (state == ST_CONT_PULSE);
      cpu_debug_get_param         = (state == ST_RD_SETUP) || (state == ST_RD_CAPTURE) ||
                                    (state == ST_RSP_WAIT && dump_active);
      cpu_debug_reg_addr          = idx;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx         <= '0;
         dump_active <= 1'b0;
         cmd_ready   <= 1'b0;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_tag     <= '0;
         rsp_err     <= 1'b0;
      end else begin
         idx         <= idx_nxt;
         dump_active <= dump_nxt;
         cmd_ready   <= (state_nxt == ST_IDLE);
         busy        <= (state_nxt != ST_IDLE) | rsp_valid_nxt;
         rsp_valid   <= rsp_valid_nxt;
         if (rsp_set) begin
            rsp_data <= rsp_data_nxt;
            rsp_tag  <= rsp_tag_nxt;
            rsp_err  <= rsp_err_nxt;
         end else if (rsp_hs) begin
            rsp_data <= '0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
         end
      end
   end

`ifdef PROCESSOR_DEBUG_CTRL_STEP_EN
   // cnt spans the whole step from the pulse; wcnt restarts on each wait state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step_active <= 1'b0;
         cnt         <= '0;
         wcnt        <= '0;
      end else begin
         step_active <= step_nxt;
         if (accept)
            cnt <= '0;
         else if (state == ST_CONT_PULSE || state == ST_STEP_WAIT_LOW || state == ST_STEP_WAIT_HIGH)
            cnt <= cnt_inc;
         if (state_nxt != state)
            wcnt <= '0;
         else if (state == ST_STEP_WAIT_LOW || state == ST_STEP_WAIT_HIGH)
            wcnt <= wcnt + TW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_processor_debug_ctrl.sv
// Scoreboard bench for processor_debug_ctrl: stimulus pushes expected responses, a monitor pops on each handshake.
module tb_processor_debug_ctrl;
   localparam int WS = 18;

   logic          clock = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [2:0]    cmd_op;
   logic [3:0]    cmd_reg;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [WS-1:0] rsp_data;
   logic [3:0]    rsp_tag;
   logic          cpu_wait_for_continue, cont, gp, busy;
   logic [3:0]    addr;
   logic [WS-1:0] cpu_debug_data;

   typedef struct packed {
      logic          err;
      logic [3:0]    tag;
      logic [WS-1:0] data;
   } exp_t;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_pop    = 0;
   int            rdy_mode = 0;
   logic          gp_seen  = 1'b0;
   logic [WS-1:0] regs[0:15];

   always #5 clock = ~clock;

   processor_debug_ctrl #(.WORD_SIZE(WS), .STEP_TIMEOUT(32)) dut (
      .clock                      (clock),
      .reset                      (reset),
      .cmd_valid                  (cmd_valid),
      .cmd_ready                  (cmd_ready),
      .cmd_op                     (cmd_op),
      .cmd_reg                    (cmd_reg),
      .rsp_valid                  (rsp_valid),
      .rsp_ready                  (rsp_ready),
      .rsp_data                   (rsp_data),
      .rsp_tag                    (rsp_tag),
      .rsp_err                    (rsp_err),
      .cpu_wait_for_continue      (cpu_wait_for_continue),
      .cpu_wait_continue_execution(cont),
      .cpu_debug_get_param        (gp),
      .cpu_debug_reg_addr         (addr),
      .cpu_debug_data             (cpu_debug_data),
      .busy                       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic e, input logic [3:0] t, input logic [WS-1:0] d);
      return {e, t, d};
   endfunction

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got err=%0b tag=%0d data=0x%0h, expected no response",
                        rsp_err, rsp_tag, rsp_data);
            end else begin
               e = sb_q.pop_front();
               check("rsp", 32'({rsp_err, rsp_tag, rsp_data}), 32'(e));
               n_pop++;
            end
         end
      end
   end

   always @(negedge clock) if (gp) gp_seen = 1'b1;

   // rsp_ready pattern: 0 = always high, 1 = toggling, 2 = held low
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ~rsp_ready;
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   // Processor debug read port: data follows the address one cycle later
   initial begin
      logic [3:0] a;
      cpu_debug_data = '0;
      forever begin
         @(negedge clock);
         a = addr;
         @(posedge clock);
         #1 cpu_debug_data = regs[a];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [3:0] rg);
      logic ok;
      ok        = 1'b0;
      cmd_op    = op;
      cmd_reg   = rg;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      check("cmd_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (sb_q.size() == 0 && !busy) begin
            done = 1'b1;
            break;
         end
      end
      check("idle_reached", 32'(done), 32'd1);
      tick();
   endtask

   initial begin
      int   viol, k, pulses, base;
      logic ok;
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_reg = '0;
      cpu_wait_for_continue = 1'b1;
      for (int i = 0; i < 16; i++) regs[i] = '0;
      #2;
      check("rst_flags", 32'({cmd_ready, rsp_valid, rsp_err, busy, cont, gp}), 32'd0);
      check("rst_data", 32'({rsp_tag, rsp_data, addr}), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      tick();
      tick();
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);

      // READ_REG r3 while halted: response two edges after accept
      regs[3] = 18'h00123;
      send(3'd2, 4'd3);
      sb_q.push_back(mk(1'b0, 4'd3, 18'h00123));
      @(negedge clock);
      check("rd_get_param", 32'(gp), 32'd1);
      check("rd_addr", 32'(addr), 32'd3);
      check("rd_valid_n1", 32'(rsp_valid), 32'd0);
      @(negedge clock);
      check("rd_valid_n1b", 32'(rsp_valid), 32'd0);
      @(negedge clock);
      check("rd_valid_n2", 32'(rsp_valid), 32'd1);
      wait_idle(20);

      // READ_REG while running: error, held with rsp_ready low, no freeze
      cpu_wait_for_continue = 1'b0;
      gp_seen = 1'b0;
      rdy_mode = 2;
      send(3'd2, 4'd0);
      sb_q.push_back(mk(1'b1, 4'd0, 18'h0));
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      check("rej_held", 32'({rsp_valid, rsp_err, rsp_tag, rsp_data}), 32'({1'b1, 1'b1, 4'd0, 18'h0}));
      rdy_mode = 0;
      wait_idle(20);
      check("rej_no_get_param", 32'(gp_seen), 32'd0);

      // STATUS both ways, bad index, reserved op
      send(3'd0, 4'd0);
      sb_q.push_back(mk(1'b0, 4'd0, 18'h0));
      wait_idle(20);
      cpu_wait_for_continue = 1'b1;
      send(3'd0, 4'd0);
      sb_q.push_back(mk(1'b0, 4'd0, 18'h1));
      wait_idle(20);
      send(3'd2, 4'd9);
      sb_q.push_back(mk(1'b1, 4'd0, 18'h0));
      wait_idle(20);
      send(3'd7, 4'd2);
      sb_q.push_back(mk(1'b1, 4'd0, 18'h0));
      wait_idle(20);

      // DUMP with rsp_ready toggling
      for (int i = 0; i < 9; i++) regs[i] = WS'(i * 16);
      rdy_mode = 1;
      send(3'd3, 4'd0);
      for (int i = 0; i < 9; i++) sb_q.push_back(mk(1'b0, 4'(i), WS'(i * 16)));
      viol = 0;
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         #1;
         if (!gp || cmd_ready) viol++;
         if (sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("dump_done", 32'(ok), 32'd1);
      check("dump_held", 32'(viol), 32'd0);
      rdy_mode = 0;
      wait_idle(20);
      check("dump_release", 32'(gp), 32'd0);

      // DUMP with rsp_ready high: 27 cycles
      send(3'd3, 4'd0);
      for (int i = 0; i < 9; i++) sb_q.push_back(mk(1'b0, 4'(i), WS'(i * 16)));
      k = 0;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (cmd_ready) begin
            k = c;
            break;
         end
      end
      check("dump_cycles", 32'(k), 32'd27);
      wait_idle(20);

      // CONTINUE halted: one pulse; running: error, no pulse
      send(3'd1, 4'd0);
      sb_q.push_back(mk(1'b0, 4'd0, 18'h0));
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (cont) pulses++;
      end
      check("cont_pulses", 32'(pulses), 32'd1);
      wait_idle(20);
      cpu_wait_for_continue = 1'b0;
      send(3'd1, 4'd0);
      sb_q.push_back(mk(1'b1, 4'd0, 18'h0));
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (cont) pulses++;
      end
      check("cont_run_pulses", 32'(pulses), 32'd0);
      wait_idle(20);
      cpu_wait_for_continue = 1'b1;

`ifdef PROCESSOR_DEBUG_CTRL_STEP_EN
      // Drop 2 edges after pulse, raise 10 later: 12 plus the detecting cycle = 13
      send(3'd4, 4'd0);
      sb_q.push_back(mk(1'b0, 4'd0, 18'd13));
      @(negedge clock);
      check("step_pulse", 32'(cont), 32'd1);
      repeat (2) @(posedge clock);
      #1 cpu_wait_for_continue = 1'b0;
      repeat (10) @(posedge clock);
      #1 cpu_wait_for_continue = 1'b1;
      wait_idle(50);
      send(3'd4, 4'd0);
      sb_q.push_back(mk(1'b1, 4'd0, 18'h0));
      @(negedge clock);
      repeat (2) @(posedge clock);
      #1 cpu_wait_for_continue = 1'b0;
      wait_idle(200);
      send(3'd4, 4'd0);
      sb_q.push_back(mk(1'b1, 4'd0, 18'h0));
      wait_idle(20);
      cpu_wait_for_continue = 1'b1;
`else
      send(3'd4, 4'd0);
      sb_q.push_back(mk(1'b1, 4'd0, 18'h0));
      wait_idle(20);
`endif

      // Reset in the middle of a DUMP, after tag 4 is taken
      regs[8] = 18'h2ABCD;
      base = n_pop;
      send(3'd3, 4'd0);
      for (int i = 0; i < 9; i++) sb_q.push_back(mk(1'b0, 4'(i), regs[i]));
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         #1;
         if (n_pop >= base + 5) begin
            ok = 1'b1;
            break;
         end
      end
      check("mid_dump_progress", 32'(ok), 32'd1);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_flags", 32'({cmd_ready, rsp_valid, rsp_err, busy, cont, gp}), 32'd0);
      check("mid_rst_data", 32'({rsp_tag, rsp_data, addr}), 32'd0);
      sb_q.delete();
      @(posedge clock);
      #1 reset = 1'b0;
      tick();
      tick();
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      send(3'd2, 4'd8);
      sb_q.push_back(mk(1'b0, 4'd8, 18'h2ABCD));
      wait_idle(20);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
